// File: rtl/gpio_bank_controller.sv
// gpio_bank_controller
//   AXI4-Lite GPIO bank with up to 32 pins. Each pin has a direction bit and
//   an output data bit, and DATA_OUT can be set or cleared atomically. Inputs
//   are synchronised, optionally debounced, and drive per-pin edge/level
//   interrupts. Status bits are sticky and write-1-to-clear, and they are
//   combined into one registered level interrupt.
//
//   Optional feature macro: GPIO_DEBOUNCE_EN
//     When defined, each pin gets a stability counter of DEBOUNCE_CYCLES.
//     When undefined, the filtered value is the synchroniser output.
//
//   Ports
//     clk, rst_n                  clock, async active-low reset
//     aw*/w*/b*                   AXI4-Lite write address/data/response
//     ar*/r*                      AXI4-Lite read address/data
//     gpio_out[GPIO_WIDTH]        registered output data
//     gpio_out_en[GPIO_WIDTH]     registered drive enable (1 = drive)
//     gpio_in[GPIO_WIDTH]         asynchronous pin inputs
//     gpio_irq                    registered level interrupt
//
//   Register map (decoded on addr[5:2]):
//     0x00 DATA_OUT RW  0x04 DATA_IN RO  0x08 DIR RW    0x0C INT_EN RW
//     0x10 INT_TYPE RW  0x14 INT_POL RW  0x18 INT_STATUS W1C
//     0x1C SET WO       0x20 CLR WO      >=0x24 SLVERR
module gpio_bank_controller #(
  parameter int GPIO_WIDTH      = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [31:0]           araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_out_en,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  gpio_irq
);

  localparam int W = GPIO_WIDTH;

  typedef enum logic [3:0] {
    REG_DATA_OUT   = 4'd0,
    REG_DATA_IN    = 4'd1,
    REG_DIR        = 4'd2,
    REG_INT_EN     = 4'd3,
    REG_INT_TYPE   = 4'd4,
    REG_INT_POL    = 4'd5,
    REG_INT_STATUS = 4'd6,
    REG_SET        = 4'd7,
    REG_CLR        = 4'd8
  } reg_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel holding registers
  logic         r_aw_held;
  logic [3:0]   r_aw_idx;
  logic         r_w_held;
  logic [31:0]  r_wdata;
  logic [3:0]   r_wstrb;
  logic         r_bvalid;
  logic [1:0]   r_bresp;

  // Read channel
  logic         r_rvalid;
  logic [31:0]  r_rdata;
  logic [1:0]   r_rresp;

  // Register file
  logic [W-1:0] r_data_out;
  logic [W-1:0] r_dir;
  logic [W-1:0] r_int_en;
  logic [W-1:0] r_int_type;
  logic [W-1:0] r_int_pol;
  logic [W-1:0] r_int_status;
  logic [W-1:0] r_gpio_out;
  logic [W-1:0] r_gpio_out_en;
  logic         r_irq;

  // Input path
  logic [W-1:0] r_sync [SYNC_STAGES];
  logic [W-1:0] r_f_prev;
  logic [W-1:0] w_sync;
  logic [W-1:0] w_f;

  logic         w_wr_fire;
  logic         w_wr_err;
  logic [31:0]  w_bmask;
  logic [W-1:0] w_wmask;
  logic [W-1:0] w_wd;
  logic [W-1:0] w_w1c;
  logic [W-1:0] w_edge_ev;
  logic [W-1:0] w_level_ev;
  logic [W-1:0] w_event;
  logic [3:0]   w_ar_idx;
  logic [31:0]  w_rd_val;
  logic [1:0]   w_rd_resp;
  logic         w_unused_addr;

  // Bank selection happens in the interconnect; only addr[5:2] matters here.
  assign w_unused_addr = ^{awaddr[31:6], awaddr[1:0], araddr[31:6], araddr[1:0]};

  assign awready     = ~r_aw_held & ~r_bvalid;
  assign wready      = ~r_w_held & ~r_bvalid;
  assign arready     = ~r_rvalid;
  assign bvalid      = r_bvalid;
  assign bresp       = r_bresp;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign rresp       = r_rresp;
  assign gpio_out    = r_gpio_out;
  assign gpio_out_en = r_gpio_out_en;
  assign gpio_irq    = r_irq;

  // ---------------------------------------------------------------------------
  // Write path: AW and W are captured independently; the register update and
  // the B response happen together once both beats are held.
  // ---------------------------------------------------------------------------
  assign w_wr_fire = r_aw_held & r_w_held & ~r_bvalid;
  assign w_wr_err  = (r_aw_idx > 4'(REG_CLR));
  assign w_bmask   = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_wmask   = w_bmask[W-1:0];
  assign w_wd      = r_wdata[W-1:0] & w_wmask;
  assign w_w1c     = (w_wr_fire && (r_aw_idx == 4'(REG_INT_STATUS))) ? w_wd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= awaddr[5:2];
      end else if (w_wr_fire) begin
        r_aw_held <= 1'b0;
      end

      if (wvalid && wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end else if (w_wr_fire) begin
        r_w_held <= 1'b0;
      end

      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_dir      <= '0;
      r_int_en   <= '0;
      r_int_type <= '0;
      r_int_pol  <= '0;
    end else if (w_wr_fire) begin
      case (r_aw_idx)
        4'(REG_DATA_OUT): r_data_out <= (r_data_out & ~w_wmask) | w_wd;
        4'(REG_DIR):      r_dir      <= (r_dir      & ~w_wmask) | w_wd;
        4'(REG_INT_EN):   r_int_en   <= (r_int_en   & ~w_wmask) | w_wd;
        4'(REG_INT_TYPE): r_int_type <= (r_int_type & ~w_wmask) | w_wd;
        4'(REG_INT_POL):  r_int_pol  <= (r_int_pol  & ~w_wmask) | w_wd;
        4'(REG_SET):      r_data_out <= r_data_out | w_wd;
        4'(REG_CLR):      r_data_out <= r_data_out & ~w_wd;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  assign w_ar_idx = araddr[5:2];

  always_comb begin
    w_rd_val  = '0;
    w_rd_resp = RESP_OKAY;
    case (w_ar_idx)
      4'(REG_DATA_OUT):   w_rd_val = 32'(r_data_out);
      4'(REG_DATA_IN):    w_rd_val = 32'(w_f);
      4'(REG_DIR):        w_rd_val = 32'(r_dir);
      4'(REG_INT_EN):     w_rd_val = 32'(r_int_en);
      4'(REG_INT_TYPE):   w_rd_val = 32'(r_int_type);
      4'(REG_INT_POL):    w_rd_val = 32'(r_int_pol);
      4'(REG_INT_STATUS): w_rd_val = 32'(r_int_status);
      4'(REG_SET):        w_rd_val = '0;
      4'(REG_CLR):        w_rd_val = '0;
      default:            w_rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_val;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser and optional debounce
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [W-1:0]  r_f;
  logic [CW-1:0] r_db_cnt [W];

  // The counter tracks consecutive cycles where the synchronised pin
  // disagrees with the filtered value; the filtered value flips on the
  // DEBOUNCE_CYCLES-th disagreeing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f <= '0;
      for (int unsigned i = 0; i < W; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < W; i++) begin
        if (w_sync[i] != r_f[i]) begin
          if (r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_f[i]      <= w_sync[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_f = r_f;
`else
  assign w_f = w_sync;
`endif

  // ---------------------------------------------------------------------------
  // Interrupt detection, sticky status and output registers
  // ---------------------------------------------------------------------------
  assign w_edge_ev  = (r_int_pol & w_f & ~r_f_prev) | (~r_int_pol & ~w_f & r_f_prev);
  assign w_level_ev = ~(w_f ^ r_int_pol);
  assign w_event    = r_int_en & ((r_int_type & w_edge_ev) | (~r_int_type & w_level_ev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_prev      <= '0;
      r_int_status  <= '0;
      r_irq         <= 1'b0;
      r_gpio_out    <= '0;
      r_gpio_out_en <= '0;
    end else begin
      r_f_prev      <= w_f;
      // A new event on a bit being cleared in the same cycle keeps it set.
      r_int_status  <= (r_int_status & ~w_w1c) | w_event;
      r_irq         <= |(r_int_status & r_int_en);
      r_gpio_out    <= r_data_out;
      r_gpio_out_en <= r_dir;
    end
  end

endmodule

// File: doc/gpio_bank_controller.md
# gpio_bank_controller

Parametrised AXI4-Lite GPIO bank: up to 32 pins with per-pin direction, atomic set/clear of output data, input synchronisation and per-pin configurable edge/level interrupts with sticky write-1-to-clear status. It sits on the peripheral AXI4-Lite interconnect beside the other register-mapped peripherals and drives one level interrupt line to the system interrupt controller. It integrates its own AXI4-Lite slave logic.

## Interface
- `GPIO_WIDTH`, 32 — pin count, 1..32; register bits above `GPIO_WIDTH-1` read 0 and ignore writes.
- `SYNC_STAGES`, 2 — input synchroniser flops per pin, ≥2.
- `DEBOUNCE_CYCLES`, 16 — stability window, ≥1; used only with `GPIO_DEBOUNCE_EN`.
- `clk` in 1 — single clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `awvalid` in 1, `awready` out 1, `awaddr` in 32 — write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in 32, `wstrb` in 4 — write data channel.
- `bvalid` out 1, `bready` in 1, `bresp` out 2 — write response.
- `arvalid` in 1, `arready` out 1, `araddr` in 32 — read address.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rresp` out 2 — read data.
- `gpio_out` out `GPIO_WIDTH` — output data.
- `gpio_out_en` out `GPIO_WIDTH` — 1 = drive, 0 = high-Z.
- `gpio_in` in `GPIO_WIDTH` — asynchronous pin inputs.
- `gpio_irq` out 1 — registered level interrupt.

## Operation
- Decode uses `addr[5:2]`; upper bits are ignored because the interconnect decodes the bank.
- Register map: 0x00 DATA_OUT RW; 0x04 DATA_IN RO (filtered pins); 0x08 DIR RW; 0x0C INT_EN RW; 0x10 INT_TYPE RW (1 = edge, 0 = level); 0x14 INT_POL RW (edge: 1 = rising, 0 = falling; level: 1 = high, 0 = low); 0x18 INT_STATUS W1C; 0x1C SET WO (DATA_OUT |= wdata); 0x20 CLR WO (DATA_OUT &= ~wdata). SET and CLR read 0.
- Offsets ≥0x24 return SLVERR (2'b10): writes have no effect, reads return 0. All other accesses return OKAY.
- `wstrb` is honoured per byte on every writable register, including SET, CLR and W1C.
- Input path: `gpio_in` → synchroniser → optional debounce → filtered value `f`; `f_prev` is `f` delayed one cycle.
- An event sets INT_STATUS[i] only when INT_EN[i]=1:
  - edge/rising: `f & ~f_prev`
  - edge/falling: `~f & f_prev`
  - level: `f == INT_POL`
- A level source still active re-sets its status the cycle after a W1C.
- If an event and a W1C hit the same bit in the same cycle, set wins.
- Clearing INT_EN does not clear INT_STATUS.
- `gpio_irq` is registered as `|(INT_STATUS & INT_EN)`.
- Reset values are all 0: every register, synchroniser and debounce stage, `f_prev`, `gpio_out`, `gpio_out_en`, `gpio_irq`, and all `*valid` outputs. `awready`, `wready` and `arready` are 1 after reset.
- Asserting reset mid-transaction drops the transaction; no response is issued.

## Timing
- AW and W are accepted independently. A channel's ready stays high until that channel is captured and deasserts while the captured beat waits for its partner or while `bvalid`=1.
- When both beats are held (same or different cycles), at edge t:
  - the register updates at t+1;
  - `bvalid` asserts at t+1 and holds with `bresp` stable until `bready`;
  - ready re-asserts the cycle after the B handshake.
- `arready` = ~`rvalid`. An AR handshake at t gives `rvalid`/`rdata`/`rresp` at t+1, held until `rready`.
- A read and a write in the same cycle are independent. A read returns the pre-write value.
- Pin latency without debounce:
  - DATA_IN reflects a pin change SYNC_STAGES cycles after it is sampled;
  - INT_STATUS sets 1 cycle later;
  - `gpio_irq` asserts 1 cycle after that.
- Register-to-pin latency: `gpio_out` and `gpio_out_en` change the cycle after a write's register update (registered outputs).

## Configuration
- `GPIO_DEBOUNCE_EN` defined:
  - each pin has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`;
  - `f[i]` takes the synchronised value only after it differs from `f[i]` for DEBOUNCE_CYCLES consecutive cycles;
  - any return to the `f[i]` value resets the counter;
  - this adds DEBOUNCE_CYCLES latency.
- Undefined: `f` equals the synchroniser output, no counters are built and `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Write DIR=0x0000_00FF, then DATA_OUT=0xA5A5_A5A5 with wstrb=4'b0001 → `gpio_out_en`=0xFF, `gpio_out`=0x0000_00A5, bresp=OKAY.
- SET 0x0000_0F00 then CLR 0x0000_0005 from DATA_OUT=0xA5 → DATA_OUT reads 0x0000_0FA0.
- INT_EN[3]=1, INT_TYPE[3]=1, INT_POL[3]=1; drive `gpio_in[3]` 0→1 → INT_STATUS=0x8 after SYNC_STAGES+1 cycles, `gpio_irq`=1 one cycle later. W1C 0x8 → irq falls. A falling edge leaves status at 0.
- Level-high on pin 0 held high; W1C 0x1 → status re-sets next cycle and irq stays 1. W1C coincident with a new edge → bit remains 1.
- AW sent 3 cycles before W → single bvalid 1 cycle after W accepted. Read offset 0x30 → rresp=2'b10, rdata=0. Stall `rready` 5 cycles → `rdata` stable and `arready`=0.
- With `GPIO_DEBOUNCE_EN`, DEBOUNCE_CYCLES=4: a 3-cycle glitch → DATA_IN unchanged; a 4-cycle stable change → DATA_IN updates.
